// File: rtl/petris_pkg.sv
// rtl/petris_pkg.sv - shared constants, opcodes, states and score table for the play controller
package petris_pkg;

    localparam int OP_RIGHT  = 0;
    localparam int OP_LEFT   = 1;
    localparam int OP_DOWN   = 2;
    localparam int OP_ROTATE = 3;
    localparam int OP_START  = 4;

    localparam logic [2:0] PIECE_I     = 3'd1;
    localparam logic [2:0] PIECE_J     = 3'd2;
    localparam logic [2:0] PIECE_L     = 3'd3;
    localparam logic [2:0] PIECE_S     = 3'd4;
    localparam logic [2:0] PIECE_BLOCK = 3'd5;
    localparam logic [2:0] PIECE_T     = 3'd6;
    localparam logic [2:0] PIECE_Z     = 3'd7;

    typedef enum logic [2:0] {
        CMD_RESET_BOARD = 3'd0,
        CMD_SPAWN       = 3'd1,
        CMD_GRAVITY     = 3'd2,
        CMD_DOWN        = 3'd3,
        CMD_LEFT        = 3'd4,
        CMD_RIGHT       = 3'd5,
        CMD_ROTATE      = 3'd6,
        CMD_CLEAR       = 3'd7
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RSTB  = 3'd1,
        ST_SPAWN = 3'd2,
        ST_PLAY  = 3'd3,
        ST_ISSUE = 3'd4,
        ST_WAIT  = 3'd5,
        ST_CLR   = 3'd6,
        ST_OVER  = 3'd7
    } state_e;

    // Base points per clear, before the level multiplier; out-of-range counts score nothing.
    function automatic logic [3:0] line_points(input logic [2:0] n);
        case (n)
            3'd1:    line_points = 4'd1;
            3'd2:    line_points = 4'd3;
            3'd3:    line_points = 4'd7;
            3'd4:    line_points = 4'd10;
            default: line_points = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/piece_randomizer.sv
// rtl/piece_randomizer.sv - free-running 7-bit LFSR that yields a nonzero piece code
module piece_randomizer
    import petris_pkg::*;
#(
    parameter logic [6:0] SEED = 7'h5A
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic [2:0] piece
);

    logic [6:0] lfsr;

    // x^7 + x^6 + 1, Fibonacci form
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
    end

    assign piece = (lfsr[2:0] == 3'd0) ? PIECE_BLOCK : lfsr[2:0];

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - turns frames and buttons into the serialized board-engine command stream
module game_sequencer
    import petris_pkg::*;
#(
    parameter int         FRAMES0         = 48,
    parameter int         DROP_STEP       = 3,
    parameter int         MIN_FRAMES      = 4,
    parameter int         LINES_PER_LEVEL = 10,
    parameter int         SCORE_W         = 16,
    parameter logic [6:0] LFSR_SEED       = 7'h5A
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               vsync,
    input  logic [4:0]         operation,
    output logic               cmd_valid,
    output logic [2:0]         cmd_op,
    output logic [2:0]         cmd_piece,
    input  logic               cmd_ready,
    input  logic               rsp_valid,
    input  logic               rsp_frozen,
    input  logic [2:0]         rsp_lines,
    input  logic               rsp_lost,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         level,
    output logic               playing,
    output logic               gameover
);

    state_e       state;
    logic         vs_meta, vs_sync, vs_last, start_last;
    logic         frame_tick, start_edge;
    logic         outstanding, restart;
    logic [3:0]   pend, pend_acc, sel_mask;
    logic         grav_pend, grav_expire, sel_any;
    logic [2:0]   sel_op, state_op, piece;
    logic [7:0]   grav_cnt;
    int           frames_per_drop;
    logic [7:0]   line_cnt;
    logic [8:0]   lines_sum;
    logic [2:0]   eff_lines;
    logic [3:0]   line_pts;
    logic [4:0]   lvl_p1;
    logic [8:0]   clr_points;
    logic [SCORE_W:0] score_sum;

    piece_randomizer #(.SEED(LFSR_SEED)) u_rand (
        .clock   (clock),
        .reset_n (reset_n),
        .piece   (piece)
    );

    assign frame_tick = vs_sync & ~vs_last;
    assign start_edge = operation[OP_START] & ~start_last;

    always_comb begin
        frames_per_drop = FRAMES0 - DROP_STEP * int'(level);
        if (frames_per_drop < MIN_FRAMES) frames_per_drop = MIN_FRAMES;
    end

    assign grav_expire = frame_tick && playing && (int'(grav_cnt) >= frames_per_drop - 1);

    // Opposing horizontal requests cancel rather than letting one side win.
    always_comb begin
        pend_acc = pend;
        if (frame_tick && playing) pend_acc = pend | operation[3:0];
        if (pend_acc[OP_LEFT] && pend_acc[OP_RIGHT]) begin
            pend_acc[OP_LEFT]  = 1'b0;
            pend_acc[OP_RIGHT] = 1'b0;
        end
    end

    always_comb begin
        sel_any  = 1'b1;
        sel_op   = CMD_GRAVITY;
        sel_mask = 4'd0;
        if (grav_pend) begin
            sel_op = CMD_GRAVITY;
        end else if (pend[OP_DOWN]) begin
            sel_op = CMD_DOWN;
            sel_mask[OP_DOWN] = 1'b1;
        end else if (pend[OP_LEFT]) begin
            sel_op = CMD_LEFT;
            sel_mask[OP_LEFT] = 1'b1;
        end else if (pend[OP_RIGHT]) begin
            sel_op = CMD_RIGHT;
            sel_mask[OP_RIGHT] = 1'b1;
        end else if (pend[OP_ROTATE]) begin
            sel_op = CMD_ROTATE;
            sel_mask[OP_ROTATE] = 1'b1;
        end else begin
            sel_any = 1'b0;
        end
    end

    always_comb begin
        case (state)
            ST_RSTB:  state_op = CMD_RESET_BOARD;
            ST_SPAWN: state_op = CMD_SPAWN;
            default:  state_op = CMD_CLEAR;
        endcase
    end

    assign eff_lines  = (rsp_lines > 3'd4) ? 3'd0 : rsp_lines;
    assign line_pts   = line_points(eff_lines);
    assign lvl_p1     = {1'b0, level} + 5'd1;
    assign clr_points = 9'(line_pts) * 9'(lvl_p1);
    assign score_sum  = (SCORE_W+1)'(score) + (SCORE_W+1)'(clr_points);
    assign lines_sum  = 9'(line_cnt) + 9'(eff_lines);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            vs_meta     <= 1'b0;
            vs_sync     <= 1'b0;
            vs_last     <= 1'b0;
            start_last  <= 1'b0;
            outstanding <= 1'b0;
            restart     <= 1'b0;
            pend        <= 4'd0;
            grav_pend   <= 1'b0;
            grav_cnt    <= 8'd0;
            line_cnt    <= 8'd0;
            cmd_valid   <= 1'b0;
            cmd_op      <= 3'd0;
            cmd_piece   <= 3'd0;
            score       <= '0;
            level       <= 4'd0;
            playing     <= 1'b0;
            gameover    <= 1'b0;
        end else begin
            vs_meta    <= vsync;
            vs_sync    <= vs_meta;
            vs_last    <= vs_sync;
            start_last <= operation[OP_START];

            if (frame_tick && playing) grav_cnt <= grav_expire ? 8'd0 : grav_cnt + 8'd1;
            pend <= pend_acc;
            if (grav_expire) grav_pend <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (start_edge || restart) begin
                        restart     <= 1'b0;
                        score       <= '0;
                        level       <= 4'd0;
                        line_cnt    <= 8'd0;
                        grav_cnt    <= 8'd0;
                        pend        <= 4'd0;
                        grav_pend   <= 1'b0;
                        outstanding <= 1'b0;
                        playing     <= 1'b1;
                        state       <= ST_RSTB;
                    end
                end
                // Board-level commands: launch, hand over, then wait for the response.
                ST_RSTB, ST_SPAWN, ST_CLR: begin
                    if (!cmd_valid && !outstanding) begin
                        cmd_valid <= 1'b1;
                        cmd_op    <= state_op;
                        cmd_piece <= (state == ST_SPAWN) ? piece : 3'd0;
                        if (state == ST_SPAWN) begin
                            pend      <= 4'd0;
                            grav_pend <= 1'b0;
                        end
                    end else if (cmd_valid) begin
                        if (cmd_ready) begin
                            cmd_valid   <= 1'b0;
                            outstanding <= 1'b1;
                        end
                    end else if (rsp_valid) begin
                        outstanding <= 1'b0;
                        case (state)
                            ST_RSTB: state <= ST_SPAWN;
                            ST_SPAWN: begin
                                if (rsp_lost) begin
                                    state    <= ST_OVER;
                                    playing  <= 1'b0;
                                    gameover <= 1'b1;
                                end else begin
                                    state <= ST_PLAY;
                                end
                            end
                            default: begin
                                score <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                                if (lines_sum >= 9'(LINES_PER_LEVEL)) begin
                                    line_cnt <= 8'(lines_sum - 9'(LINES_PER_LEVEL));
                                    if (level != 4'd15) level <= level + 4'd1;
                                end else begin
                                    line_cnt <= lines_sum[7:0];
                                end
                                state <= ST_SPAWN;
                            end
                        endcase
                    end
                end
                ST_PLAY: begin
                    if (sel_any) begin
                        cmd_valid <= 1'b1;
                        cmd_op    <= sel_op;
                        cmd_piece <= 3'd0;
                        state     <= ST_ISSUE;
                        if (grav_pend) grav_pend <= grav_expire;
                        else           pend      <= pend_acc & ~sel_mask;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (rsp_valid) begin
                        if ((cmd_op == CMD_GRAVITY || cmd_op == CMD_DOWN) && rsp_frozen)
                            state <= ST_CLR;
                        else
                            state <= ST_PLAY;
                    end
                end
                ST_OVER: begin
                    if (start_edge) begin
                        gameover <= 1'b0;
                        restart  <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed self-checking bench for game_sequencer
module tb_game_sequencer;

    localparam logic [2:0] C_RST = 3'd0, C_SPN = 3'd1, C_GRV = 3'd2, C_DN = 3'd3;
    localparam logic [2:0] C_LT = 3'd4, C_RT = 3'd5, C_ROT = 3'd6, C_CLR = 3'd7;
    localparam logic [4:0] B_RIGHT = 5'b00001, B_LEFT = 5'b00010, B_DOWN = 5'b00100;
    localparam logic [4:0] B_ROT = 5'b01000, B_START = 5'b10000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        vsync;
    logic [4:0]  operation;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_piece;
    logic        cmd_ready;
    logic        rsp_valid;
    logic        rsp_frozen;
    logic [2:0]  rsp_lines;
    logic        rsp_lost;
    logic [15:0] score;
    logic [3:0]  level;
    logic        playing;
    logic        gameover;

    int n_pass = 0;
    int n_total = 0;
    int exp_score = 0;
    int exp_level = 0;
    int exp_lines = 0;

    game_sequencer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .vsync      (vsync),
        .operation  (operation),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_piece  (cmd_piece),
        .cmd_ready  (cmd_ready),
        .rsp_valid  (rsp_valid),
        .rsp_frozen (rsp_frozen),
        .rsp_lines  (rsp_lines),
        .rsp_lost   (rsp_lost),
        .score      (score),
        .level      (level),
        .playing    (playing),
        .gameover   (gameover)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic frame(input logic [4:0] ops);
        @(negedge clock);
        operation = ops;
        vsync = 1'b1;
        repeat (3) @(negedge clock);
        operation = 5'd0;
        vsync = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame(5'd0);
    endtask

    task automatic press_start();
        @(negedge clock);
        operation = B_START;
        @(negedge clock);
        operation = 5'd0;
    endtask

    task automatic quiet(input int cycles, input string tag);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (cmd_valid !== 1'b0) seen++;
        end
        check(tag, seen, 0);
    endtask

    // Plays the engine: waits for a command, checks it, accepts it, then answers.
    task automatic serve(input logic [2:0] exp_op, input logic freeze_any, input logic frozen,
                         input logic [2:0] lines, input logic lost, input string tag);
        int waited = 0;
        while (cmd_valid !== 1'b1 && waited < 400) begin
            @(negedge clock);
            waited++;
        end
        check({tag, " valid"}, cmd_valid, 1);
        if (freeze_any) check({tag, " op grv/dn"}, (cmd_op === C_GRV || cmd_op === C_DN), 1);
        else            check({tag, " op"}, cmd_op, exp_op);
        if (exp_op == C_SPN) check({tag, " piece nonzero"}, (cmd_piece != 3'd0), 1);
        else                 check({tag, " piece zero"}, cmd_piece, 0);
        cmd_ready = 1'b1;
        @(negedge clock);
        cmd_ready = 1'b0;
        check({tag, " valid drop"}, cmd_valid, 0);
        rsp_valid  = 1'b1;
        rsp_frozen = frozen;
        rsp_lines  = lines;
        rsp_lost   = lost;
        @(negedge clock);
        rsp_valid  = 1'b0;
        rsp_frozen = 1'b0;
        rsp_lines  = 3'd0;
        rsp_lost   = 1'b0;
    endtask

    task automatic model_clear(input int lines);
        int pts;
        case (lines)
            1: pts = 1;
            2: pts = 3;
            3: pts = 7;
            4: pts = 10;
            default: pts = 0;
        endcase
        exp_score = exp_score + pts * (exp_level + 1);
        if (exp_score > 65535) exp_score = 65535;
        exp_lines = exp_lines + lines;
        if (exp_lines >= 10) begin
            exp_lines = exp_lines - 10;
            if (exp_level < 15) exp_level++;
        end
    endtask

    task automatic do_clear(input int lines);
        frame(B_DOWN);
        serve(C_DN, 1'b1, 1'b1, 3'd0, 1'b0, "freeze");
        serve(C_CLR, 1'b0, 1'b0, 3'(lines), 1'b0, "clear");
        model_clear(lines);
        serve(C_SPN, 1'b0, 1'b0, 3'd0, 1'b0, "spawn");
        check("clear score", score, exp_score);
        check("clear level", level, exp_level);
    endtask

    initial begin
        reset_n = 1'b0;
        vsync = 1'b0;
        operation = 5'd0;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_frozen = 1'b0;
        rsp_lines = 3'd0;
        rsp_lost = 1'b0;
        repeat (3) @(negedge clock);
        check("rst cmd_valid", cmd_valid, 0);
        check("rst cmd_op", cmd_op, 0);
        check("rst score", score, 0);
        check("rst level", level, 0);
        check("rst playing", playing, 0);
        check("rst gameover", gameover, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        quiet(10, "idle no cmd");

        // Start sequence
        press_start();
        serve(C_RST, 1'b0, 1'b0, 3'd0, 1'b0, "start rstb");
        serve(C_SPN, 1'b0, 1'b0, 3'd0, 1'b0, "start spawn");
        check("start playing", playing, 1);
        check("start score", score, 0);
        check("start level", level, 0);
        check("start gameover", gameover, 0);

        press_start();
        quiet(20, "start while playing");

        // Gravity every 48 frames at level 0
        for (int r = 0; r < 2; r++) begin
            frames(47);
            check("grav early", cmd_valid, 0);
            frame(5'd0);
            serve(C_GRV, 1'b0, 1'b0, 3'd0, 1'b0, "grav48");
        end

        // Arbitration: gravity and all four moves land on the same frame
        frames(47);
        frame(B_DOWN | B_ROT | B_LEFT | B_RIGHT);
        serve(C_GRV, 1'b0, 1'b0, 3'd0, 1'b0, "arb 1st");
        serve(C_DN, 1'b0, 1'b0, 3'd0, 1'b0, "arb 2nd");
        serve(C_ROT, 1'b0, 1'b1, 3'd0, 1'b0, "arb 3rd");
        quiet(30, "arb no lr");

        // Backpressure
        frame(B_DOWN);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("bp valid", cmd_valid, 1);
            check("bp op", cmd_op, C_DN);
        end
        serve(C_DN, 1'b0, 1'b0, 3'd0, 1'b0, "bp xfer");
        quiet(20, "bp single");

        // Ten single-line clears reach level 1
        for (int i = 0; i < 10; i++) do_clear(1);
        check("lvl1 level", level, 1);
        check("lvl1 score", score, 10);

        // 11 ticks so far this period; 45 frames per drop now
        frames(33);
        check("lvl1 grav early", cmd_valid, 0);
        frame(5'd0);
        serve(C_GRV, 1'b0, 1'b0, 3'd0, 1'b0, "lvl1 grav a");
        frames(44);
        check("lvl1 grav45 early", cmd_valid, 0);
        frame(5'd0);
        serve(C_GRV, 1'b0, 1'b0, 3'd0, 1'b0, "lvl1 grav45");

        // Four lines at level 1 are worth 20
        do_clear(4);
        check("tetris score", score, 30);

        // Saturation
        for (int i = 0; i < 1000 && exp_score < 65535; i++) do_clear(4);
        check("sat score", score, 65535);
        check("sat level", level, 15);
        do_clear(4);
        check("sat hold", score, 65535);

        // Loss and restart
        frame(B_DOWN);
        serve(C_DN, 1'b1, 1'b1, 3'd0, 1'b0, "loss freeze");
        serve(C_CLR, 1'b0, 1'b0, 3'd0, 1'b0, "loss clear");
        serve(C_SPN, 1'b0, 1'b0, 3'd0, 1'b1, "loss spawn");
        check("over gameover", gameover, 1);
        check("over playing", playing, 0);
        frame(B_DOWN);
        frame(B_ROT);
        quiet(40, "over no cmd");
        press_start();
        serve(C_RST, 1'b0, 1'b0, 3'd0, 1'b0, "restart rstb");
        check("restart score", score, 0);
        check("restart level", level, 0);
        check("restart gameover", gameover, 0);
        check("restart playing", playing, 1);
        serve(C_SPN, 1'b0, 1'b0, 3'd0, 1'b0, "restart spawn");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level play controller for the Tetris board engine.
- Turns vsync frames and player buttons into a serialized command stream to the engine: gravity, moves, rotate, freeze/clear, spawn and board reset.
- Schedules gravity by level, arbitrates player inputs, picks the next piece, and keeps score, level and game-over state.
- Sits between the input debouncer/vsync source and the board engine that owns the 10x20 board state.

Parameters:
- FRAMES0, 48: frames per gravity step at level 0.
- DROP_STEP, 3: frames removed per level.
- MIN_FRAMES, 4: floor on frames per gravity step.
- LINES_PER_LEVEL, 10: cleared lines needed per level increment.
- SCORE_W, 16: score width.
- LFSR_SEED, 7'h5A: randomizer seed; must be nonzero.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- vsync  in  1  frame strobe, asynchronous to clock.
- operation  in  5  buttons, one bit each: RIGHT=0, LEFT=1, DOWN=2, ROTATE=3, START=4.
- cmd_valid  out  1  command offered to the engine.
- cmd_op  out  3  command opcode: RESET_BOARD=0, SPAWN=1, GRAVITY=2, DOWN=3, LEFT=4, RIGHT=5, ROTATE=6, CLEAR=7.
- cmd_piece  out  3  piece code; valid with SPAWN, otherwise 0.
- cmd_ready  in  1  engine accepts the command.
- rsp_valid  in  1  one-cycle response pulse.
- rsp_frozen  in  1  piece is frozen; meaningful for GRAVITY and DOWN.
- rsp_lines  in  3  lines cleared, 0..4; meaningful for CLEAR.
- rsp_lost  in  1  spawn blocked; meaningful for SPAWN.
- score  out  SCORE_W  saturating score.
- level  out  4  current level, 0..15.
- playing  out  1  high in the play states.
- gameover  out  1  high in OVER.

Behaviour:
- Reset: all outputs 0. State=IDLE, counters 0, pending ops 0, LFSR=LFSR_SEED. Reset mid-transaction abandons the command; the engine resets on the same reset_n.
- vsync handling: 2-flop synchronizer plus rising-edge detect gives frame_tick, one clock wide.
- START detection: START is rising-edge detected in clock domain (registered previous value).
- Pending ops: on frame_tick, pend |= operation[3:0]. If LEFT and RIGHT are both pending, both are dropped.
- Gravity counter: counts frame_ticks while playing. At frames_per_drop-1 it sets grav_pend and clears itself.
  - frames_per_drop = max(MIN_FRAMES, FRAMES0 - DROP_STEP*level); compute with signed or widened arithmetic, no underflow.
  - Multiple expiries while busy collapse into a single grav_pend.
- Handshake:
  - cmd_op and cmd_piece stay stable while cmd_valid=1 and cmd_ready=0.
  - Transfer happens when cmd_valid and cmd_ready are both high.
  - cmd_valid drops the next cycle.
  - Exactly one command is outstanding until rsp_valid. rsp_valid is never in the same cycle as the transfer; if it is, it is ignored.
- FSM:
  - IDLE: on START edge, clear score, level and counters, then go to RSTB.
  - RSTB: issue RESET_BOARD; on response go to SPAWN.
  - SPAWN: latch the randomizer output into cmd_piece and clear pend and grav_pend.
    - Issue SPAWN.
    - Response with rsp_lost=1 goes to OVER; otherwise go to PLAY.
  - PLAY: select the highest-priority pending request: grav_pend > DOWN > LEFT/RIGHT > ROTATE. Clear its pending bit and go to ISSUE. With nothing pending, stay.
  - ISSUE: assert cmd_valid; on transfer go to WAIT.
  - WAIT: on response:
    - GRAVITY or DOWN with rsp_frozen=1 goes to CLR.
    - Anything else goes back to PLAY; rsp_frozen on LEFT, RIGHT or ROTATE is ignored.
  - CLR: issue CLEAR. On response:
    - score += TABLE[rsp_lines]*(level+1), with TABLE = {0,1,3,7,10} and rsp_lines > 4 treated as 0.
    - Sum is computed in SCORE_W+1 bits and saturates at all-ones.
    - Line counter advances by rsp_lines. Each time it reaches LINES_PER_LEVEL, subtract that value and increment level, saturating at 15.
    - Then go to SPAWN.
  - OVER: gameover=1, no commands issued. START edge goes to IDLE, then the start sequence runs as above.
- START while playing is ignored.
- frame_tick in any non-IDLE, non-OVER state still updates pend and the gravity counter.
- Randomizer: 7-bit Fibonacci LFSR, x^7+x^6+1, advances every clock. Piece = lfsr[2:0]; the value 000 maps to 101 (Block).

Decomposition:
- Shared package petris_pkg: piece codes, operation bit indices, cmd opcode constants, FSM state enum, score table.
- Sub-module piece_randomizer: clock, reset_n, seed parameter, piece[2:0] output, never 000.

Test Plan:
- Start sequence: reset, then START edge -> RESET_BOARD accepted; SPAWN with nonzero cmd_piece; playing=1, score=0, level=0.
- Gravity timing: FRAMES0=48, cmd_ready=1, no buttons -> GRAVITY issued after every 48 frame_ticks; rsp_frozen=0 keeps the state in PLAY.
- Arbitration: DOWN+ROTATE+LEFT+RIGHT pressed on one frame while grav_pend=1 -> order GRAVITY, DOWN, ROTATE; no LEFT or RIGHT issued.
- Backpressure: cmd_ready held low for 10 cycles -> cmd_op and cmd_valid stable throughout; exactly one transfer.
- Freeze and score:
  - DOWN response frozen=1, then CLEAR response lines=4 at level 1 -> score=20, then SPAWN.
  - Drive score to 65530 and clear 4 lines -> score=65535 (saturated).
- Level and loss: ten single-line clears -> level=1, frames_per_drop=45; SPAWN response lost=1 -> gameover=1, no further cmd_valid; START edge -> IDLE, then RESET_BOARD.
